// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, LFSR constants and width helpers for the mine game controller
package game_pkg;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_GEN     = 3'd2,
        S_PLAYING = 3'd3,
        S_DONE    = 3'd4
    } state_t;
    localparam int LFSR_W = 16;
    // Galois taps for x^16+x^14+x^13+x^11 in a right-shifting register
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/mine_game_ctrl_if.sv
// mine_game_ctrl_if: control/status bundle between cursor logic, renderer and the game controller
//  inputs to controller : start, restart, reveal_req, cursor_idx, tile_revealed, mine_revealed,
//                         flag_set, flag_clr
//  outputs of controller: mine_map, map_valid, replay_reveal, replay_idx, reveal_count,
//                         flags_left, seconds, state, endgame, win
interface mine_game_ctrl_if
    import game_pkg::*;
#(
    parameter int GRID_W  = 5,
    parameter int GRID_H  = 5,
    parameter int TIMER_W = 10
);
    localparam int N     = GRID_W * GRID_H;
    localparam int IDX_W = idx_w(N);
    localparam int CNT_W = cnt_w(N);
    logic             start;
    logic             restart;
    logic             reveal_req;
    logic [IDX_W-1:0] cursor_idx;
    logic             tile_revealed;
    logic             mine_revealed;
    logic             flag_set;
    logic             flag_clr;
    logic [N-1:0]     mine_map;
    logic             map_valid;
    logic             replay_reveal;
    logic [IDX_W-1:0] replay_idx;
    logic [CNT_W-1:0] reveal_count;
    logic [CNT_W-1:0] flags_left;
    logic [TIMER_W-1:0] seconds;
    logic [2:0]       state;
    logic             endgame;
    logic             win;
    modport slave (
        input  start, restart, reveal_req, cursor_idx, tile_revealed, mine_revealed,
               flag_set, flag_clr,
        output mine_map, map_valid, replay_reveal, replay_idx, reveal_count, flags_left,
               seconds, state, endgame, win
    );
    modport master (
        output start, restart, reveal_req, cursor_idx, tile_revealed, mine_revealed,
               flag_set, flag_clr,
        input  mine_map, map_valid, replay_reveal, replay_idx, reveal_count, flags_left,
               seconds, state, endgame, win
    );
endinterface

// File: rtl/mine_lfsr.sv
// mine_lfsr: 16-bit Galois LFSR, free-running when en is high; only rst reloads the seed
//  clk, rst (async, active-low), en: step enable, q: low OUT_W bits of the register
module mine_lfsr
    import game_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int                OUT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [OUT_W-1:0] q
);
    if (SEED == '0) begin : g_bad_seed
        $error("mine_lfsr: SEED must be nonzero");
    end
    logic [LFSR_W-1:0] r;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r <= SEED;
        else if (en) r <= (r >> 1) ^ (r[0] ? LFSR_TAPS : '0);
    end
    assign q = r[OUT_W-1:0];
endmodule

// File: rtl/mine_game_ctrl.sv
// mine_game_ctrl: Minesweeper game controller - run-time mine placement, reveal/flag/timer tracking
//  clk, rst (async, active-low) plain ports; everything else travels on bus (mine_game_ctrl_if.slave)
//  Flow IDLE->ARMED->GEN->PLAYING->DONE; restart returns to IDLE from any state.
module mine_game_ctrl
    import game_pkg::*;
#(
    parameter int                GRID_W        = 5,
    parameter int                GRID_H        = 5,
    parameter int                NUM_MINES     = 6,
    parameter int                TICKS_PER_SEC = 25_000_000,
    parameter int                TIMER_W       = 10,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
    input logic              clk,
    input logic              rst,
    mine_game_ctrl_if.slave  bus
);
    localparam int N     = GRID_W * GRID_H;
    localparam int IDX_W = idx_w(N);
    localparam int CNT_W = cnt_w(N);
    localparam int SAFE  = N - NUM_MINES;
    localparam int TK_W  = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] MINES = CNT_W'(NUM_MINES);
    if (NUM_MINES < 1 || NUM_MINES > N - 1) begin : g_bad_mines
        $error("mine_game_ctrl: NUM_MINES must be in 1..N-1");
    end
    state_t             state, nxt;
    logic [IDX_W-1:0]   cand, replay_idx;
    logic [N-1:0]       mine_map, cand_oh;
    logic [CNT_W-1:0]   placed, reveal_count, flag_cnt;
    logic [TK_W-1:0]    ticks;
    logic [TIMER_W-1:0] seconds;
    logic               replay_reveal, endgame, win;
    logic               accept, last_mine, win_hit, lose_hit;
    mine_lfsr #(.SEED(LFSR_SEED), .OUT_W(IDX_W)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .q   (cand)
    );
    // candidate is rejected when off-grid, on the first click, or already mined
    assign cand_oh   = {{(N-1){1'b0}}, 1'b1} << cand;
    assign accept    = cand <= LAST && cand != replay_idx && !(|(mine_map & cand_oh));
    assign last_mine = accept && placed == MINES - 1'b1;
    assign lose_hit  = bus.mine_revealed;
    assign win_hit   = bus.tile_revealed && reveal_count == CNT_W'(SAFE - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    nxt = bus.start ? S_ARMED : S_IDLE;
            S_ARMED:   nxt = bus.reveal_req && bus.cursor_idx <= LAST ? S_GEN : S_ARMED;
            S_GEN:     nxt = last_mine ? S_PLAYING : S_GEN;
            S_PLAYING: nxt = lose_hit || win_hit ? S_DONE : S_PLAYING;
            S_DONE:    nxt = S_DONE;
            default:   nxt = S_IDLE;
        endcase
        if (bus.restart) nxt = S_IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mine_map      <= '0;
            placed        <= '0;
            replay_idx    <= '0;
            replay_reveal <= 1'b0;
            reveal_count  <= '0;
            flag_cnt      <= '0;
            ticks         <= '0;
            seconds       <= '0;
            endgame       <= 1'b0;
            win           <= 1'b0;
        end else if (bus.restart) begin
            mine_map      <= '0;
            placed        <= '0;
            replay_reveal <= 1'b0;
            reveal_count  <= '0;
            flag_cnt      <= '0;
            ticks         <= '0;
            seconds       <= '0;
            endgame       <= 1'b0;
            win           <= 1'b0;
        end else begin
            replay_reveal <= state == S_GEN && last_mine;
            if (state == S_ARMED && nxt == S_GEN) replay_idx <= bus.cursor_idx;
            if (state == S_GEN && accept) begin
                mine_map <= mine_map | cand_oh;
                placed   <= placed + 1'b1;
            end
            if (state == S_PLAYING) begin
                if (bus.tile_revealed && reveal_count != CNT_W'(SAFE)) reveal_count <= reveal_count + 1'b1;
                if (bus.flag_set && !bus.flag_clr && flag_cnt != CNT_W'(N)) flag_cnt <= flag_cnt + 1'b1;
                else if (bus.flag_clr && !bus.flag_set && flag_cnt != '0) flag_cnt <= flag_cnt - 1'b1;
                if (ticks == TK_W'(TICKS_PER_SEC - 1)) begin
                    ticks <= '0;
                    if (seconds != '1) seconds <= seconds + 1'b1;
                end else begin
                    ticks <= ticks + 1'b1;
                end
                // a mine hit in the same cycle as the final safe reveal is a loss
                if (lose_hit || win_hit) begin
                    endgame <= 1'b1;
                    win     <= !lose_hit;
                end
            end
        end
    end
    assign bus.mine_map      = mine_map;
    assign bus.map_valid     = state == S_PLAYING || state == S_DONE;
    assign bus.replay_reveal = replay_reveal;
    assign bus.replay_idx    = replay_idx;
    assign bus.reveal_count  = reveal_count;
    assign bus.flags_left    = flag_cnt > MINES ? '0 : MINES - flag_cnt;
    assign bus.seconds       = seconds;
    assign bus.state         = state;
    assign bus.endgame       = endgame;
    assign bus.win           = win;
endmodule

// File: tb/tb_mine_game_ctrl.sv
// tb_mine_game_ctrl: directed, table-driven bench for mine_game_ctrl (5x5, 6 mines, 4 ticks/s)
module tb_mine_game_ctrl;
    localparam logic [15:0] SEED = 16'hACE1;
    typedef struct {
        logic       t, m, fs, fc;
        logic [4:0] rc, fl;
        logic       eg, w;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [15:0] m_lfsr;
    logic [31:0] m_map;
    vec_t tbl [17];
    always #5 clk = ~clk;
    mine_game_ctrl_if #(.GRID_W(5), .GRID_H(5), .TIMER_W(10)) a ();
    mine_game_ctrl_if #(.GRID_W(5), .GRID_H(5), .TIMER_W(2))  b ();
    mine_game_ctrl #(.GRID_W(5), .GRID_H(5), .NUM_MINES(6), .TICKS_PER_SEC(4), .TIMER_W(10),
                     .LFSR_SEED(SEED)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    mine_game_ctrl #(.GRID_W(5), .GRID_H(5), .NUM_MINES(6), .TICKS_PER_SEC(4), .TIMER_W(2),
                     .LFSR_SEED(SEED)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
    assign b.start         = a.start;
    assign b.restart       = a.restart;
    assign b.reveal_req    = a.reveal_req;
    assign b.cursor_idx    = a.cursor_idx;
    assign b.tile_revealed = a.tile_revealed;
    assign b.mine_revealed = a.mine_revealed;
    assign b.flag_set      = a.flag_set;
    assign b.flag_clr      = a.flag_clr;
    // reference Galois LFSR x^16+x^14+x^13+x^11, right shift, never touched by restart
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= SEED;
        else m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic pulse(input logic t, input logic m, input logic fs, input logic fc);
        a.tile_revealed = t;
        a.mine_revealed = m;
        a.flag_set      = fs;
        a.flag_clr      = fc;
        @(negedge clk);
        a.tile_revealed = 1'b0;
        a.mine_revealed = 1'b0;
        a.flag_set      = 1'b0;
        a.flag_clr      = 1'b0;
    endtask
    task automatic do_restart();
        a.restart = 1'b1;
        @(negedge clk);
        a.restart = 1'b0;
        chk("restart_idle", a.state, 0);
    endtask
    // start + first click, then follow the placement with the reference LFSR;
    // returns one PLAYING edge after entry
    task automatic begin_game(input int idx);
        bit done;
        int cnt;
        a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        chk("armed", a.state, 1);
        a.cursor_idx = 5'(idx);
        a.reveal_req = 1'b1;
        @(negedge clk);
        a.reveal_req = 1'b0;
        chk("gen", a.state, 2);
        m_map = '0;
        cnt = 0;
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            int cand;
            cand = int'(m_lfsr[4:0]);
            if (cand < 25 && cand != idx && !m_map[cand]) begin
                m_map[cand] = 1'b1;
                cnt++;
            end
            if (cnt == 6) begin
                done = 1'b1;
                chk("pre_replay", a.replay_reveal, 0);
            end
            @(negedge clk);
        end
        chk("gen_bound", done, 1);
        chk("playing", a.state, 3);
        chk("map_valid", a.map_valid, 1);
        chk("mine_map", a.mine_map, m_map);
        chk("popcount", $countones(a.mine_map), 6);
        chk("safe_first", a.mine_map[idx], 0);
        chk("replay_pulse", a.replay_reveal, 1);
        chk("replay_idx", a.replay_idx, idx);
        @(negedge clk);
        chk("replay_end", a.replay_reveal, 0);
    endtask
    initial begin
        logic [31:0] prev_map;
        a.start = 0; a.restart = 0; a.reveal_req = 0; a.cursor_idx = 0;
        a.tile_revealed = 0; a.mine_revealed = 0; a.flag_set = 0; a.flag_clr = 0;
        tbl[0]  = '{0, 0, 1, 0, 0, 5, 0, 0};
        tbl[1]  = '{0, 0, 1, 1, 0, 5, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 0, 6, 0, 0};
        tbl[3]  = '{0, 0, 0, 1, 0, 6, 0, 0};
        tbl[4]  = '{0, 0, 1, 0, 0, 5, 0, 0};
        tbl[5]  = '{0, 0, 1, 0, 0, 4, 0, 0};
        tbl[6]  = '{0, 0, 1, 0, 0, 3, 0, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 2, 0, 0};
        tbl[8]  = '{0, 0, 1, 0, 0, 1, 0, 0};
        tbl[9]  = '{0, 0, 1, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 1, 0, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 1, 0, 1, 0, 0};
        tbl[13] = '{1, 0, 0, 0, 1, 1, 0, 0};
        tbl[14] = '{1, 0, 1, 0, 2, 0, 0, 0};
        tbl[15] = '{1, 0, 0, 1, 3, 1, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 3, 1, 0, 0};
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("rst_state", a.state, 0);
        chk("rst_map", a.mine_map, 0);
        chk("rst_map_valid", a.map_valid, 0);
        chk("rst_replay", a.replay_reveal, 0);
        chk("rst_replay_idx", a.replay_idx, 0);
        chk("rst_reveal_count", a.reveal_count, 0);
        chk("rst_flags_left", a.flags_left, 6);
        chk("rst_seconds", a.seconds, 0);
        chk("rst_endgame", a.endgame, 0);
        chk("rst_win", a.win, 0);
        a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        chk("pre_async_armed", a.state, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_state", a.state, 0);
        chk("async_flags_left", a.flags_left, 6);
        chk("async_map_valid", a.map_valid, 0);
        chk("async_state_b", b.state, 0);
        @(negedge clk);
        rst = 1'b1;
        a.cursor_idx = 5'd3;
        a.reveal_req = 1'b1;
        @(negedge clk);
        a.reveal_req = 1'b0;
        chk("idle_reveal_ignored", a.state, 0);
        a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        a.cursor_idx = 5'd25;
        a.reveal_req = 1'b1;
        @(negedge clk);
        chk("idx25_ignored", a.state, 1);
        a.cursor_idx = 5'd31;
        @(negedge clk);
        a.reveal_req = 1'b0;
        chk("idx31_ignored", a.state, 1);
        // game 1: timer, flag/reveal table, loss, frozen DONE, restart beats start
        begin_game(12);
        repeat (8) @(negedge clk);
        chk("sec_9cyc", a.seconds, 2);
        chk("sec_9cyc_w2", b.seconds, 2);
        repeat (31) @(negedge clk);
        chk("sec_40cyc", a.seconds, 10);
        chk("sec_sat_w2", b.seconds, 3);
        for (int i = 0; i < 17; i++) begin
            pulse(tbl[i].t, tbl[i].m, tbl[i].fs, tbl[i].fc);
            chk($sformatf("vec%0d_reveal_count", i), a.reveal_count, tbl[i].rc);
            chk($sformatf("vec%0d_flags_left", i), a.flags_left, tbl[i].fl);
            chk($sformatf("vec%0d_endgame", i), a.endgame, tbl[i].eg);
            chk($sformatf("vec%0d_win", i), a.win, tbl[i].w);
        end
        pulse(0, 1, 0, 0);
        chk("loss_state", a.state, 4);
        chk("loss_endgame", a.endgame, 1);
        chk("loss_win", a.win, 0);
        pulse(1, 0, 1, 0);
        chk("done_reveal_frozen", a.reveal_count, 3);
        chk("done_flags_frozen", a.flags_left, 1);
        chk("done_seconds_frozen", a.seconds, 14);
        chk("done_state", a.state, 4);
        a.restart = 1'b1;
        a.start = 1'b1;
        @(negedge clk);
        a.restart = 1'b0;
        a.start = 1'b0;
        chk("rs_state", a.state, 0);
        chk("rs_map", a.mine_map, 0);
        chk("rs_map_valid", a.map_valid, 0);
        chk("rs_reveal_count", a.reveal_count, 0);
        chk("rs_flags_left", a.flags_left, 6);
        chk("rs_seconds", a.seconds, 0);
        chk("rs_endgame", a.endgame, 0);
        chk("rs_win", a.win, 0);
        // game 2: flag saturation at N, then a full win
        begin_game(0);
        repeat (26) pulse(0, 0, 1, 0);
        chk("flags_max", a.flags_left, 0);
        repeat (19) pulse(0, 0, 0, 1);
        chk("flags_sat6", a.flags_left, 0);
        pulse(0, 0, 0, 1);
        chk("flags_sat5", a.flags_left, 1);
        for (int i = 1; i <= 19; i++) begin
            pulse(1, 0, 0, 0);
            if (i == 18) begin
                chk("win18_count", a.reveal_count, 18);
                chk("win18_endgame", a.endgame, 0);
            end
        end
        chk("win_state", a.state, 4);
        chk("win_endgame", a.endgame, 1);
        chk("win_win", a.win, 1);
        chk("win_count", a.reveal_count, 19);
        chk("win_seconds", a.seconds, 16);
        repeat (5) pulse(1, 0, 1, 0);
        chk("win_count_frozen", a.reveal_count, 19);
        chk("win_seconds_frozen", a.seconds, 16);
        chk("win_flags_frozen", a.flags_left, 1);
        // game 3: last safe reveal and mine hit together
        do_restart();
        begin_game(24);
        repeat (18) pulse(1, 0, 0, 0);
        chk("tie18_endgame", a.endgame, 0);
        pulse(1, 1, 0, 0);
        chk("tie_state", a.state, 4);
        chk("tie_endgame", a.endgame, 1);
        chk("tie_win", a.win, 0);
        for (int i = 0; i < 50; i++) begin
            do_restart();
            begin_game(i == 0 ? 0 : i == 1 ? 24 : int'($urandom_range(0, 24)));
        end
        // restart mid-GEN, then the same first click must produce a different field
        do_restart();
        begin_game(7);
        prev_map = m_map;
        do_restart();
        a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        a.cursor_idx = 5'd7;
        a.reveal_req = 1'b1;
        @(negedge clk);
        a.reveal_req = 1'b0;
        @(negedge clk);
        chk("midgen_in_gen", a.state, 2);
        a.restart = 1'b1;
        @(negedge clk);
        a.restart = 1'b0;
        chk("midgen_state", a.state, 0);
        chk("midgen_map", a.mine_map, 0);
        chk("midgen_map_valid", a.map_valid, 0);
        begin_game(7);
        chk("new_map_differs", a.mine_map != prev_map, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
